// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and the result sign-fix/select helper for the RV32M execute unit.
package ex_muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Product and quotient share the sign flag; the remainder follows the dividend.
    function automatic logic [XLEN-1:0] muldiv_select(
        input logic [2:0]        f3,
        input logic [2*XLEN-1:0] prod,
        input logic [XLEN-1:0]   quot,
        input logic [XLEN-1:0]   rem,
        input logic              sign,
        input logic              rsign
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = sign  ? -prod : prod;
        q = sign  ? -quot : quot;
        r = rsign ? -rem  : rem;
        case (f3)
            F3_MUL:                      return p[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: return p[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             return q;
            default:                     return r;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv_wb.sv
// Registered write-back stage: result, destination and write-enable, all reset to 0.
module ex_muldiv_wb
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             load_i,
    input  logic [WIDTH-1:0] result_i,
    input  logic [4:0]       rd_addr_i,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_addr_o,
    output logic             we_o
);

    logic [WIDTH-1:0] result_q;
    logic [4:0]       rd_addr_q;
    logic             we_q;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            result_q  <= '0;
            rd_addr_q <= '0;
            we_q      <= DISABLE;
        end else begin
            we_q <= load_i;
            if (load_i) begin
                result_q  <= result_i;
                rd_addr_q <= rd_addr_i;
            end
        end
    end

    assign result_o  = result_q;
    assign rd_addr_o = rd_addr_q;
    assign we_o      = we_q;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring divide,
// stalling the pipeline while busy and emitting a one-cycle register write.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rest,
    input  logic [6:0]       idex2ex_opcode_i,
    input  logic [2:0]       idex2ex_funct3_i,
    input  logic [31:0]      idex2ex_id_ins_i,
    input  logic [WIDTH-1:0] idex2ex_source1_i,
    input  logic [WIDTH-1:0] idex2ex_source2_i,
    input  logic [4:0]       idex2ex_rd_addr_i,
    input  logic             cu2ex_flush_i,
    output logic             ex2cu_hold_flag_o,
    output logic [WIDTH-1:0] ex2wb_result_o,
    output logic [4:0]       ex2wb_rd_addr_o,
    output logic             ex2wb_we_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic [63:0]     acc_q, acc_d;
    logic [63:0]     mcand_q, mcand_d;
    logic [31:0]     mplier_q, mplier_d;
    logic [31:0]     rem_q, rem_d;
    logic            sign_q, sign_d;
    logic            rsign_q, rsign_d;

    logic            start, special, div_zero, div_ovf;
    logic            sa, sb;
    logic [31:0]     mag_a, mag_b;
    logic [32:0]     shifted;
    logic            load;
    logic [WIDTH-1:0] result_d;
    logic            we_raw;
    logic            unused_ins;

    assign unused_ins = ^idex2ex_id_ins_i[24:0];

    always_comb begin
        start = (state_q == S_IDLE) && (idex2ex_opcode_i == OPCODE_OP) &&
                (idex2ex_id_ins_i[31:25] == FUNCT7_MULDIV) && !cu2ex_flush_i;
        sa = idex2ex_source1_i[31] &&
             (idex2ex_funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
        sb = idex2ex_source2_i[31] &&
             (idex2ex_funct3_i inside {F3_MULH, F3_DIV, F3_REM});
        mag_a    = sa ? -idex2ex_source1_i : idex2ex_source1_i;
        mag_b    = sb ? -idex2ex_source2_i : idex2ex_source2_i;
        div_zero = idex2ex_funct3_i[2] && (idex2ex_source2_i == '0);
        div_ovf  = (idex2ex_funct3_i inside {F3_DIV, F3_REM}) &&
                   (idex2ex_source1_i == 32'h8000_0000) && (idex2ex_source2_i == '1);
        special  = div_zero || div_ovf;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (count_q == 5'd31) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cu2ex_flush_i) state_d = S_IDLE;
    end

    // Outputs load on the edge entering DONE so the write is visible during DONE itself.
    always_comb begin
        ex2cu_hold_flag_o = rest && !cu2ex_flush_i && (start || (state_q == S_CALC));
        load              = (state_d == S_DONE);
    end

    always_comb begin
        count_d  = count_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        shifted  = {rem_q, acc_q[31]};
        if (start) begin
            count_d = '0;
            f3_d    = idex2ex_funct3_i;
            rd_d    = idex2ex_rd_addr_i;
            if (special) begin
                acc_d   = {32'b0, (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000)};
                rem_d   = div_zero ? idex2ex_source1_i : '0;
                sign_d  = 1'b0;
                rsign_d = 1'b0;
            end else begin
                mcand_d  = {32'b0, mag_a};
                mplier_d = mag_b;
                acc_d    = idex2ex_funct3_i[2] ? {32'b0, mag_a} : '0;
                rem_d    = '0;
                sign_d   = sa ^ sb;
                rsign_d  = sa;
            end
        end else if (state_q == S_CALC) begin
            count_d = count_q + 5'd1;
            if (f3_q[2]) begin
                if (shifted >= {1'b0, mplier_q}) begin
                    rem_d = 32'(shifted - {1'b0, mplier_q});
                    acc_d = {32'b0, acc_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    acc_d = {32'b0, acc_q[30:0], 1'b0};
                end
            end else begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
        end
        result_d = muldiv_select(f3_d, acc_d, acc_d[31:0], rem_d, sign_d, rsign_d);
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            count_q  <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
        end
    end

    ex_muldiv_wb #(.WIDTH(WIDTH)) u_wb (
        .clk       (clk),
        .rest      (rest),
        .load_i    (load),
        .result_i  (result_d),
        .rd_addr_i (rd_d),
        .result_o  (ex2wb_result_o),
        .rd_addr_o (ex2wb_rd_addr_o),
        .we_o      (we_raw)
    );

    // A flush arriving in DONE still kills the pending write.
    assign ex2wb_we_o = we_raw && !cu2ex_flush_i;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M vectors, stall length and write timing.
module tb_ex_muldiv;

    localparam logic [6:0] OP_OP  = 7'b0110011;
    localparam logic [6:0] F7_M   = 7'b0000001;

    logic        clk;
    logic        rest;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] ins;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd;
    logic        flush;
    logic        hold;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          checks;
    int          failures;
    int          writes;
    int          exp_writes;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk               (clk),
        .rest              (rest),
        .idex2ex_opcode_i  (opcode),
        .idex2ex_funct3_i  (funct3),
        .idex2ex_id_ins_i  (ins),
        .idex2ex_source1_i (rs1),
        .idex2ex_source2_i (rs2),
        .idex2ex_rd_addr_i (rd),
        .cu2ex_flush_i     (flush),
        .ex2cu_hold_flag_o (hold),
        .ex2wb_result_o    (result),
        .ex2wb_rd_addr_o   (rd_out),
        .ex2wb_we_o        (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rest && we) begin
            exp_t e;
            writes++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h rd=%0d required=none", result, rd_out);
            end else begin
                e = sb.pop_front();
                chk("wb_result", result, e.res);
                chk("wb_rd", {27'b0, rd_out}, {27'b0, e.rd});
                chk("wb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic set_nop();
        opcode = 7'b0;
        funct3 = 3'b0;
        ins    = 32'b0;
        rs1    = 32'b0;
        rs2    = 32'b0;
        rd     = 5'b0;
    endtask

    // Called at posedge+1; holds the instruction while the unit stalls, returns at posedge+1.
    task automatic issue(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                         input logic expect_wr, input logic [31:0] exp_res,
                         input int unsigned exp_hold, input string name);
        int unsigned n;
        exp_t e;
        opcode = op;
        funct3 = f3;
        ins    = {f7, 25'b0};
        rs1    = a;
        rs2    = b;
        rd     = d;
        if (expect_wr) begin
            e.res = exp_res;
            e.rd  = d;
            e.cyc = cyc + exp_hold;
            sb.push_back(e);
            exp_writes++;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (!hold) break;
            n++;
            if (n >= 200) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout actual=%0d required=%0d", name, n, exp_hold);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_hold"}, n, exp_hold);
        @(posedge clk);
        #1;
        set_nop();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        writes = 0;
        exp_writes = 0;
        rest  = 1'b0;
        flush = 1'b0;
        set_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_rd", {27'b0, rd_out}, 32'h0);
        chk("rst_we", {31'b0, we}, 32'h0);
        chk("rst_hold", {31'b0, hold}, 32'h0);
        @(posedge clk);
        #1;
        rest = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_OP, F7_M, 3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  1, 32'hFFFF_FFEB, 33, "mul");
        issue(OP_OP, F7_M, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  1, 32'h4000_0000, 33, "mulh");
        issue(OP_OP, F7_M, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  1, 32'hFFFF_FFFE, 33, "mulhu");
        issue(OP_OP, F7_M, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1, 32'hFFFF_FFFF, 33, "mulhsu");
        issue(OP_OP, F7_M, 3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  1, 32'hFFFF_FFFD, 33, "div");
        issue(OP_OP, F7_M, 3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 1, 32'hFFFF_FFFF, 33, "rem");
        issue(OP_OP, F7_M, 3'd5, 32'd100,       32'd7,         5'd11, 1, 32'd14,        33, "divu");
        issue(OP_OP, F7_M, 3'd7, 32'd100,       32'd7,         5'd12, 1, 32'd2,         33, "remu");
        issue(OP_OP, F7_M, 3'd4, 32'd9,         32'd0,         5'd13, 1, 32'hFFFF_FFFF, 1,  "div0");
        issue(OP_OP, F7_M, 3'd7, 32'd5,         32'd0,         5'd14, 1, 32'd5,         1,  "remu0");
        issue(OP_OP, F7_M, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 32'h8000_0000, 1,  "divovf");
        issue(OP_OP, F7_M, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'h0,         1,  "removf");
        issue(OP_OP, F7_M, 3'd6, 32'hFFFF_FFFB, 32'd0,         5'd17, 1, 32'hFFFF_FFFB, 1,  "rem0");

        // Flush at CALC count 10 (start cycle + 11).
        opcode = OP_OP; funct3 = 3'd0; ins = {F7_M, 25'b0}; rs1 = 32'd5; rs2 = 32'd6; rd = 5'd30;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_hold", {31'b0, hold}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(OP_OP, F7_M, 3'd0, 32'd3, 32'd4, 5'd18, 1, 32'd12, 33, "mul_after_flush");

        // Flush coinciding with a start must not begin the operation.
        opcode = OP_OP; funct3 = 3'd0; ins = {F7_M, 25'b0}; rs1 = 32'd2; rs2 = 32'd2; rd = 5'd29;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_start_hold", {31'b0, hold}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        set_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("flush_start_idle", {31'b0, hold}, 32'h0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of CALC.
        opcode = OP_OP; funct3 = 3'd0; ins = {F7_M, 25'b0}; rs1 = 32'd9; rs2 = 32'd9; rd = 5'd28;
        repeat (6) @(posedge clk);
        #1;
        rest = 1'b0;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_rd", {27'b0, rd_out}, 32'h0);
        chk("midrst_we", {31'b0, we}, 32'h0);
        chk("midrst_hold", {31'b0, hold}, 32'h0);
        set_nop();
        @(posedge clk);
        #1;
        rest = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_OP, 7'b0, 3'd0, 32'd1, 32'd2, 5'd3, 0, 32'h0, 0, "add");
        issue(OP_OP, F7_M, 3'd0, 32'd5,         32'd6,         5'd19, 1, 32'd30, 33, "mul_b2b_a");
        issue(OP_OP, F7_M, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 1, 32'd1,  33, "mul_b2b_b");

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pending_expected", sb.size(), 32'h0);
        chk("write_count", writes, exp_writes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
